// File: rtl/comp_seq_ctrl.sv
// comp_seq_ctrl: multi-cycle MSB-first comparator built on one cascaded 2-bit slice
module comp_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int IDXW  = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic             ready,
  output logic             done,
  output logic             isEqual,
  output logic             isGreaterThan,
  output logic             isLessThan
);
  localparam logic [IDXW-1:0] IDX_TOP = IDXW'(WIDTH/2-1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             eq_q, eq_d, gt_q, gt_d;
  logic             is_eq_q, is_eq_d, is_gt_q, is_gt_d, is_lt_q, is_lt_d;
  logic [1:0]       pa, pb;
  logic             slice_eq, slice_gt;
  assign ready         = state_q == IDLE;
  assign done          = state_q == DONE;
  assign isEqual       = is_eq_q;
  assign isGreaterThan = is_gt_q;
  assign isLessThan    = is_lt_q;
  always_comb begin
    pa       = a_q[{idx_q, 1'b0} +: 2];
    pb       = b_q[{idx_q, 1'b0} +: 2];
    slice_gt = gt_q | (pa > pb);
    slice_eq = eq_q & ~gt_q & (pa == pb);
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    idx_d    = idx_q;
    eq_d     = eq_q;
    gt_d     = gt_q;
    is_eq_d  = is_eq_q;
    is_gt_d  = is_gt_q;
    is_lt_d  = is_lt_q;
    case (state_q)
      IDLE: if (start) begin
        // flipping the sign bit maps two's complement onto an unsigned order
        a_d     = is_signed ? {~data_operandA[WIDTH-1], data_operandA[WIDTH-2:0]} : data_operandA;
        b_d     = is_signed ? {~data_operandB[WIDTH-1], data_operandB[WIDTH-2:0]} : data_operandB;
        eq_d    = 1'b1;
        gt_d    = 1'b0;
        idx_d   = IDX_TOP;
        is_eq_d = 1'b0;
        is_gt_d = 1'b0;
        is_lt_d = 1'b0;
        state_d = RUN;
      end
      RUN: begin
        eq_d = slice_eq;
        gt_d = slice_gt;
        if (idx_q == '0 || !slice_eq) begin
          is_eq_d = slice_eq;
          is_gt_d = slice_gt;
          is_lt_d = ~slice_eq & ~slice_gt;
          state_d = DONE;
        end else begin
          idx_d = idx_q - IDXW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= IDX_TOP;
      eq_q    <= 1'b1;
      gt_q    <= 1'b0;
      is_eq_q <= 1'b0;
      is_gt_q <= 1'b0;
      is_lt_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      is_eq_q <= is_eq_d;
      is_gt_q <= is_gt_d;
      is_lt_q <= is_lt_d;
    end
  end
endmodule

// File: tb/tb_comp_seq_ctrl.sv
// tb_comp_seq_ctrl: directed compares with a queue-based scoreboard checked on each done pulse
module tb_comp_seq_ctrl;
  localparam int W = 32;
  logic         clock = 0, reset_n = 0, start = 0, is_signed = 0;
  logic [W-1:0] opa = '0, opb = '0;
  logic         ready, done, is_eq, is_gt, is_lt;
  int           cyc = 0, checks = 0, errors = 0;
  typedef struct {logic [2:0] res; int cyc;} exp_t;
  exp_t sb[$];
  exp_t m_e;
  comp_seq_ctrl #(.WIDTH(W), .IDXW(4)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .is_signed(is_signed),
    .data_operandA(opa), .data_operandB(opb), .ready(ready), .done(done),
    .isEqual(is_eq), .isGreaterThan(is_gt), .isLessThan(is_lt)
  );
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  always @(negedge clock) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected done=0 (cycle %0d)", cyc);
      end else begin
        m_e = sb.pop_front();
        check("result_eq_gt_lt", {29'd0, is_eq, is_gt, is_lt}, {29'd0, m_e.res});
        check("done_cycle", cyc, m_e.cyc);
      end
    end
  end
  // called at a negedge; returns at the negedge where ready is back
  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                    input logic [2:0] res, input int lat, input bit spam);
    int n, t;
    n = cyc;
    opa = a; opb = b; is_signed = s; start = 1;
    sb.push_back('{res, n + lat});
    @(negedge clock);
    t = 0;
    while (ready !== 1'b1 && t < 100) begin
      if (spam) begin
        start = 1; opa = $urandom; opb = $urandom; is_signed = 1'($urandom);
      end else start = 0;
      @(negedge clock);
      t++;
    end
    start = 0;
    check("ready_return_cycle", cyc, n + lat + 1);
  endtask
  initial begin
    int n;
    repeat (2) @(negedge clock);
    check("reset_ready", {31'd0, ready}, 1);
    check("reset_done", {31'd0, done}, 0);
    check("reset_results", {29'd0, is_eq, is_gt, is_lt}, 0);
    reset_n = 1;
    @(negedge clock);
    op(32'h12345678, 32'h12345678, 0, 3'b100, 17, 0);
    op(32'h80000000, 32'h00000001, 0, 3'b010, 2, 0);
    op(32'h80000000, 32'h00000001, 1, 3'b001, 2, 0);
    op(32'hFFFFFFFF, 32'hFFFFFFFE, 1, 3'b010, 17, 0);
    op(32'h00000005, 32'h00000004, 0, 3'b010, 17, 0);
    op(32'h00000004, 32'h00000005, 0, 3'b001, 17, 0);
    op(32'h00010000, 32'h00020000, 0, 3'b001, 9, 0);
    op(32'hFFFFFFFF, 32'h00000000, 1, 3'b001, 2, 0);
    op(32'h7FFFFFFF, 32'h80000000, 1, 3'b010, 2, 0);
    op(32'h00000300, 32'h00000200, 0, 3'b010, 13, 1);
    op(32'h00000001, 32'h00000002, 0, 3'b001, 17, 0);
    n = cyc;
    opa = 32'h12345678; opb = 32'h12345678; is_signed = 0; start = 1;
    @(negedge clock);
    start = 0;
    while (cyc < n + 5) @(negedge clock);
    reset_n = 0;
    @(negedge clock);
    reset_n = 1;
    check("abort_ready", {31'd0, ready}, 1);
    check("abort_done", {31'd0, done}, 0);
    check("abort_results", {29'd0, is_eq, is_gt, is_lt}, 0);
    repeat (20) @(negedge clock);
    op(32'hCAFEF00D, 32'hCAFEF00D, 1, 3'b100, 17, 0);
    repeat (3) @(negedge clock);
    check("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
